// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr - round-robin N-to-1 stream multiplexer with a registered output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-lane valid, bit i = lane i
//   in_data    packed lane data, lane i at [i*DATA_W +: DATA_W]
//   in_ready   per-lane ready, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_sel    lane index the registered word came from
//   out_ready  downstream accepts the word
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | output register holds no word; any granted lane may load
// FULL  | output register holds a word; reload only while out_ready=1
module mux_nx1_rr #(
    parameter int NUM_IN  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SEL = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [NUM_SEL-1:0]       out_sel,
    input  logic                     out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [NUM_SEL-1:0] LAST_LANE = NUM_SEL'(NUM_IN - 1);

    state_t             state;
    logic [NUM_SEL-1:0] ptr;
    logic               load_en;
    logic               grant_found;
    logic [NUM_SEL-1:0] grant_idx;
    logic [NUM_SEL-1:0] cand_idx;
    logic [NUM_SEL-1:0] next_ptr;
    logic [DATA_W-1:0]  grant_data;
    logic [DATA_W-1:0]  lane_data [NUM_IN];
    int                 cand;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign lane_data[g] = in_data[g*DATA_W +: DATA_W];
    end

    assign out_valid = (state == FULL);
    assign load_en   = (state == EMPTY) || out_ready;

    // Search from ptr upward, wrapping at NUM_IN rather than at 2**NUM_SEL so
    // that non-power-of-two lane counts never visit a nonexistent lane.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            cand_idx = NUM_SEL'(cand);
            if (!grant_found && in_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant_data = lane_data[grant_idx];
    assign next_ptr   = (grant_idx == LAST_LANE) ? '0 : grant_idx + NUM_SEL'(1);

    // Gated by rst_n so no producer sees a handshake while the block is held in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (load_en) begin
            if (grant_found) begin
                state    <= FULL;
                out_data <= grant_data;
                out_sel  <= grant_idx;
                ptr      <= next_ptr;
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
module tb_mux_nx1_rr;

    logic        clk;
    logic        rst_n;

    // index 0 drives the 8-lane instance, index 1 the 5-lane instance
    logic [7:0]  iv  [2];
    logic [7:0]  id  [2][8];
    logic        ord [2];
    logic [7:0]  rdy [2];
    logic        ov  [2];
    logic [7:0]  od  [2];
    logic [2:0]  os  [2];

    logic [63:0] in_data8;
    logic [39:0] in_data5;
    logic [7:0]  in_ready8;
    logic [4:0]  in_ready5;
    logic        out_valid8, out_valid5;
    logic [7:0]  out_data8, out_data5;
    logic [2:0]  out_sel8, out_sel5;

    // behavioural model state
    logic        m_v [2];
    logic [7:0]  m_d [2];
    int          m_s [2];
    int          m_p [2];
    logic [7:0]  acc [2];

    int n_cmp = 0;
    int n_bad = 0;

    always_comb begin
        for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = id[0][i];
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = id[1][i];
    end

    assign rdy[0] = in_ready8;
    assign rdy[1] = {3'b000, in_ready5};
    assign ov[0]  = out_valid8;
    assign ov[1]  = out_valid5;
    assign od[0]  = out_data8;
    assign od[1]  = out_data5;
    assign os[0]  = out_sel8;
    assign os[1]  = out_sel5;

    mux_nx1_rr #(.NUM_IN(8), .DATA_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[0]),
        .in_data   (in_data8),
        .in_ready  (in_ready8),
        .out_valid (out_valid8),
        .out_data  (out_data8),
        .out_sel   (out_sel8),
        .out_ready (ord[0])
    );

    mux_nx1_rr #(.NUM_IN(5), .DATA_W(8)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[1][4:0]),
        .in_data   (in_data5),
        .in_ready  (in_ready5),
        .out_valid (out_valid5),
        .out_data  (out_data5),
        .out_sel   (out_sel5),
        .out_ready (ord[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] @%0t: got 0x%0h expected 0x%0h", name, u, $time, act, exp);
        end
    endtask

    // Model: each lane count n; search ptr, ptr+1, ... mod n for the first valid lane.
    int         mn, mg;
    logic       mld;
    logic [7:0] mer;
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mn     = (u == 0) ? 8 : 5;
            mer    = '0;
            mld    = 1'b0;
            mg     = -1;
            if (!rst_n) begin
                m_v[u] = 1'b0;
                m_d[u] = '0;
                m_s[u] = 0;
                m_p[u] = 0;
            end else begin
                mld = !m_v[u] || ord[u];
                for (int k = 0; k < mn; k++) begin
                    if (mg < 0 && iv[u][(m_p[u] + k) % mn]) mg = (m_p[u] + k) % mn;
                end
                if (mld && mg >= 0) mer[mg] = 1'b1;
            end
            chk("in_ready",  u, 32'(rdy[u]), 32'(mer));
            chk("out_valid", u, 32'(ov[u]),  32'(m_v[u]));
            chk("out_data",  u, 32'(od[u]),  32'(m_d[u]));
            chk("out_sel",   u, 32'(os[u]),  32'(m_s[u]));
            acc[u] = mer;
            if (rst_n && mld) begin
                if (mg >= 0) begin
                    m_v[u] = 1'b1;
                    m_d[u] = id[u][mg];
                    m_s[u] = mg;
                    m_p[u] = (mg + 1) % mn;
                end else begin
                    m_v[u] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step();
        int n;
        step();
        for (int u = 0; u < 2; u++) begin
            n = (u == 0) ? 8 : 5;
            for (int i = 0; i < n; i++) begin
                if (!iv[u][i] || acc[u][i]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        iv[u][i] = 1'b1;
                        id[u][i] = 8'($urandom);
                    end else begin
                        iv[u][i] = 1'b0;
                    end
                end
            end
            ord[u] = ($urandom_range(0, 99) < 70);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            iv[u]  = '0;
            ord[u] = 1'b1;
            acc[u] = '0;
            m_v[u] = 1'b0;
            m_d[u] = '0;
            m_s[u] = 0;
            m_p[u] = 0;
            for (int i = 0; i < 8; i++) id[u][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single lane 5 from ptr 0
        iv[0]    = 8'b0010_0000;
        id[0][5] = 8'hA5;
        #1 chk("single_ready", 0, 32'(rdy[0]), 32'h20);
        step();
        iv[0]    = 8'h90;
        id[0][4] = 8'h44;
        id[0][7] = 8'h77;
        #1;
        chk("single_valid", 0, 32'(ov[0]), 32'd1);
        chk("single_data",  0, 32'(od[0]), 32'hA5);
        chk("single_sel",   0, 32'(os[0]), 32'd5);
        chk("model_sel",    0, 32'(m_s[0]), 32'd5);
        // ptr now 6: lane 7 wins over lane 4
        chk("ptr6_ready",   0, 32'(rdy[0]), 32'h80);
        step();
        ord[0] = 1'b0;
        #1;
        chk("ptr6_sel",  0, 32'(os[0]), 32'd7);
        chk("ptr6_data", 0, 32'(od[0]), 32'h77);

        // asynchronous reset with a word held and lane 4 still pending
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 0, 32'(ov[0]),  32'd0);
        chk("rst_data",  0, 32'(od[0]),  32'd0);
        chk("rst_sel",   0, 32'(os[0]),  32'd0);
        chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
        iv[0] = '0;
        step();
        step();
        rst_n  = 1'b1;
        ord[0] = 1'b1;
        step();
        step();
        chk("idle_valid", 0, 32'(ov[0]), 32'd0);

        // round robin, all lanes valid
        for (int i = 0; i < 8; i++) id[0][i] = 8'(8'h10 + i);
        iv[0] = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            step();
            #1;
            chk("rr_valid", 0, 32'(ov[0]), 32'd1);
            chk("rr_sel",   0, 32'(os[0]), 32'(c % 8));
            chk("rr_data",  0, 32'(od[0]), 32'(8'h10 + (c % 8)));
        end
        iv[0] = '0;

        // backpressure: lanes 2 and 3, stall 4 cycles after first load
        step();
        iv[0]    = 8'h0C;
        id[0][2] = 8'h22;
        id[0][3] = 8'h33;
        step();
        iv[0]  = 8'h08;
        ord[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_sel",   0, 32'(os[0]),  32'd2);
            chk("bp_data",  0, 32'(od[0]),  32'h22);
            chk("bp_ready", 0, 32'(rdy[0]), 32'd0);
            step();
        end
        ord[0] = 1'b1;
        #1 chk("bp_release_ready", 0, 32'(rdy[0]), 32'h08);
        step();
        iv[0] = '0;
        #1;
        chk("bp_next_sel",  0, 32'(os[0]), 32'd3);
        chk("bp_next_data", 0, 32'(od[0]), 32'h33);

        // drain to empty
        step();
        #1;
        chk("drain_valid", 0, 32'(ov[0]), 32'd0);
        chk("drain_data",  0, 32'(od[0]), 32'h33);
        chk("drain_sel",   0, 32'(os[0]), 32'd3);

        // wrap on the 5-lane instance: move ptr to 4, then lanes 0 and 4
        iv[1]    = 8'h08;
        id[1][3] = 8'h03;
        step();
        iv[1]    = 8'h11;
        id[1][0] = 8'hA0;
        id[1][4] = 8'hB4;
        #1 chk("wrap_ready4", 1, 32'(rdy[1]), 32'h10);
        step();
        iv[1] = 8'h01;
        #1;
        chk("wrap_sel4",   1, 32'(os[1]),  32'd4);
        chk("wrap_data4",  1, 32'(od[1]),  32'hB4);
        chk("wrap_ready0", 1, 32'(rdy[1]), 32'h01);
        step();
        iv[1]    = 8'h03;
        id[1][1] = 8'hC1;
        #1;
        chk("wrap_sel0",   1, 32'(os[1]),  32'd0);
        chk("wrap_data0",  1, 32'(od[1]),  32'hA0);
        chk("wrap_ready1", 1, 32'(rdy[1]), 32'h02);
        chk("model_ptr",   1, 32'(m_p[1]), 32'd1);
        step();
        iv[1] = 8'h01;
        step();
        iv[1] = '0;
        step();

        // randomized traffic on both instances, checked every cycle by the model
        for (int c = 0; c < 3000; c++) rand_step();
        for (int u = 0; u < 2; u++) begin
            iv[u]  = '0;
            ord[u] = 1'b1;
        end
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
